// File: rtl/sign_apply_pkg.sv
// Purpose : shared types and constants for the sign_apply bit-serial loader.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
package sign_apply_pkg;

    // Controller states for the start/busy/done handshake.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Sign convention shared with the sign-detection block.
    localparam logic SIGN_POS = 1'b0;
    localparam logic SIGN_NEG = 1'b1;

endpackage

// File: rtl/sign_apply_serial_negate_cell.sv
// Purpose : one-bit serial two's-complement negator ("copy up to and including the first 1, invert the rest").
// Latency : bit_out is combinational from bit_in; seen_one updates on each enabled clock edge.
// Backpressure: none; the caller advances it with enable.
//
// Ports:
//   clock, reset   rising-edge clock, asynchronous active-high reset
//   clear          restart a word (clears seen_one); has priority over enable
//   enable         consume bit_in on this edge
//   negate         1 = negate the word, 0 = pass bits through
//   bit_in         current magnitude bit, LSB first
//   bit_out        converted bit for the current cycle
module serial_negate_cell (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    input  logic negate,
    input  logic bit_in,
    output logic bit_out
);

    logic seen_one;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            seen_one <= 1'b0;
        end else if (clear) begin
            seen_one <= 1'b0;
        end else if (enable) begin
            seen_one <= seen_one | bit_in;
        end
    end

    // Bits after the first 1 are inverted; the first 1 itself and the zeros below pass unchanged.
    assign bit_out = bit_in ^ (negate & seen_one);

endmodule

// File: rtl/sign_apply.sv
// Purpose : sign-magnitude to two's-complement loader, bit-serial LSB first, shared via start/busy/done.
// Latency : start accepted at E0, number/overflow update at EN, done high the cycle after; next start at E(N+2).
// Backpressure: start is sampled only in IDLE; requests during SHIFT/DONE are dropped, not queued.
//
// Ports:
//   clock, reset   rising-edge clock, asynchronous active-high reset (aborts any conversion, no done)
//   start          request, sampled only in IDLE together with num_signal and magnitude
//   num_signal     sign to apply (SIGN_POS / SIGN_NEG)
//   magnitude      N-bit unsigned magnitude
//   busy           high while shifting (exactly N cycles per request)
//   done           one-cycle pulse; number/overflow valid from this cycle on
//   number         N-bit two's-complement result, holds the last result
//   overflow       last request was not representable, holds the last value
//
// Build option: SIGN_APPLY_SAT_EN -- when defined, overflowed results saturate to the
// most positive / most negative value instead of wrapping modulo 2^N.
module sign_apply
    import sign_apply_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic         num_signal,
    input  logic [N-1:0] magnitude,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] number,
    output logic         overflow
);

    localparam int CNT_W = $clog2(N);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    state_t         state;
    state_t         state_nxt;
    logic [N-1:0]   mag_sr;
    // Only N-1 result bits are stored; the Nth bit is appended combinationally on the final edge.
    logic [N-2:0]   res_sr;
    logic [N-1:0]   res_full;
    logic           sgn;
    logic           ovf_next;
    logic [CNT_W-1:0] cnt;
    logic           out_bit;
    logic           accept;
    logic           shift_en;
    logic           last_bit;
    logic           ovf_calc;
    logic [N-1:0]   final_num;

    assign accept   = (state == IDLE) && start;
    assign shift_en = (state == SHIFT);
    assign last_bit = shift_en && (cnt == CNT_LAST);
    assign res_full = {out_bit, res_sr};

    // Negative side reaches one further than positive: -2^(N-1) is representable, +2^(N-1) is not.
    always_comb begin
        ovf_calc = magnitude[N-1];
        if (num_signal == SIGN_NEG) begin
            ovf_calc = magnitude[N-1] & (|magnitude[N-2:0]);
        end
    end

`ifdef SIGN_APPLY_SAT_EN
    always_comb begin
        final_num = res_full;
        if (ovf_next) begin
            final_num = (sgn == SIGN_NEG) ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
        end
    end
`else
    assign final_num = res_full;
`endif

    serial_negate_cell u_negate (
        .clock   (clock),
        .reset   (reset),
        .clear   (accept),
        .enable  (shift_en),
        .negate  (sgn),
        .bit_in  (mag_sr[0]),
        .bit_out (out_bit)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (cnt == CNT_LAST) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath: shift registers, bit counter and the latched request.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mag_sr   <= '0;
            res_sr   <= '0;
            sgn      <= SIGN_POS;
            ovf_next <= 1'b0;
            cnt      <= '0;
        end else if (accept) begin
            mag_sr   <= magnitude;
            res_sr   <= '0;
            sgn      <= num_signal;
            ovf_next <= ovf_calc;
            cnt      <= '0;
        end else if (shift_en) begin
            mag_sr   <= {1'b0, mag_sr[N-1:1]};
            res_sr   <= res_full[N-1:1];
            // Stops at N-1 on the last edge; leaves SHIFT before it could wrap.
            if (!last_bit) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Visible results move only on the final shift edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            number   <= '0;
            overflow <= 1'b0;
        end else if (last_bit) begin
            number   <= final_num;
            overflow <= ovf_next;
        end
    end

endmodule

// File: doc/sign_apply.md
Name: sign_apply

Overview:
- Inverse of the sign-detection block: takes a sign flag plus an unsigned magnitude and produces the N-bit two's-complement number.
- Conversion is bit-serial, LSB first, one bit per clock, using the "copy up to and including the first 1, invert the rest" rule.
- Sits in front of the register file as the sign-magnitude → two's-complement loader.
- Uses a start/busy/done handshake, so it is shared by several requesters without a wide adder.

Parameters:
- N, 8, data width in bits of the magnitude and the result; N ≥ 2.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- num_signal  input  1  sign to apply: 0 = positive/zero, 1 = negative
- magnitude  input  N  unsigned magnitude; sampled with start
- busy  output  1  high while in SHIFT
- done  output  1  one-cycle pulse; number and overflow are valid from this cycle on
- number  output  N  signed two's-complement result; holds the last result
- overflow  output  1  last request was not representable; holds the last value

Behaviour:
- Reset (asynchronous, active-high):
  - state = IDLE; busy = 0; done = 0; number = 0; overflow = 0.
  - Internal shift registers, bit counter and seen_one flag are cleared.
  - Reset mid-operation aborts the conversion; no done pulse is issued for the aborted request.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - On an edge with start = 1: latch magnitude into mag_sr, latch num_signal into sgn, clear res_sr, counter = 0, seen_one = 0, compute ovf_next; go to SHIFT.
  - start = 0: stay in IDLE.
- SHIFT, each edge:
  - b = mag_sr[0]; out_bit = b XOR (sgn AND seen_one).
  - res_sr shifts right with out_bit entering at bit N-1; mag_sr shifts right.
  - seen_one |= b; counter increments.
  - When counter = N-1 on this edge: copy the final result into number, copy ovf_next into overflow, go to DONE.
- DONE: done = 1 for exactly one cycle; next edge goes to IDLE.
- Latency:
  - The start-accepting edge is E0; number updates at edge EN.
  - done is high during the cycle after EN.
  - The next start is accepted at E(N+2) at the earliest.
- start is ignored in SHIFT and DONE; it is not queued.
- number and overflow do not change outside the EN edge or reset. During SHIFT they keep showing the previous result.
- Overflow rule, evaluated on the latched magnitude:
  - num_signal = 0: overflow if magnitude[N-1] = 1, i.e. magnitude > 2^(N-1)-1.
  - num_signal = 1: overflow if magnitude > 2^(N-1); magnitude = 2^(N-1) gives -2^(N-1) with no overflow.
- Zero: magnitude = 0 gives number = 0 for either sign. Negative zero is normalised by the algorithm itself, not by special-casing.
- Without saturation, an overflowed result is the modulo-2^N wrap: the bit-serial output for the given sgn and magnitude.
- Counter width: $clog2(N) bits; it never wraps within a request.

Optional Feature:
- Macro: SIGN_APPLY_SAT_EN.
- Defined: on the EN edge, if ovf_next = 1, number is loaded with 2^(N-1)-1 when sgn = 0, or with -2^(N-1) when sgn = 1, instead of the serial result. overflow is still reported.
- Undefined: number always takes the wrapped serial result; overflow is a flag only.

Decomposition:
- Package sign_apply_pkg:
  - state typedef / localparams: IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2.
  - Sign convention constants: SIGN_POS = 1'b0, SIGN_NEG = 1'b1.
- Sub-module serial_negate_cell:
  - Holds the seen_one flip-flop and the XOR.
  - Inputs: clock, reset, clear, enable, negate, bit_in. Output: bit_out (combinational).
  - The top level keeps the FSM, counter, shift registers and output registers.

Test Plan (N = 8):
- Reset mid-SHIFT: start with num_signal = 1, magnitude = 8'd5; assert reset after E3 → busy = 0, number = 0, overflow = 0 immediately; no done pulse; the next start converts normally.
- Negative: num_signal = 1, magnitude = 8'd5 → done one cycle after E8; number = 8'hFB (-5); overflow = 0; busy high for exactly 8 cycles.
- Positive and zero:
  - num_signal = 0, magnitude = 8'd127 → number = 8'h7F, overflow = 0.
  - num_signal = 1, magnitude = 8'd0 → number = 8'h00, overflow = 0.
- Boundaries:
  - num_signal = 1, magnitude = 8'd128 → number = 8'h80, overflow = 0.
  - num_signal = 0, magnitude = 8'd128 → overflow = 1; number = 8'h80 without SIGN_APPLY_SAT_EN, 8'h7F with it.
  - num_signal = 1, magnitude = 8'd200 → overflow = 1; number = 8'h38 without SIGN_APPLY_SAT_EN, 8'h80 with it.
- Handshake: hold start high continuously with changing magnitude → only requests sampled in IDLE are converted, one every 10 cycles; start during SHIFT/DONE does not alter the result; number holds its old value until E8.
